// File: rtl/vga_fb_reader_if.sv
// rtl/vga_fb_reader_if.sv - frame-buffer read port and VGA output bundle for vga_fb_reader
interface vga_fb_reader_if #(
    parameter int c_nb_img_pxls = 17,
    parameter int c_nb_buf      = 12
);
    logic [c_nb_img_pxls-1:0] fb_addr;
    logic [c_nb_buf-1:0]      fb_pxl;
    logic [3:0]               vga_r;
    logic [3:0]               vga_g;
    logic [3:0]               vga_b;
    logic                     vga_hs;
    logic                     vga_vs;
    logic                     vga_de;
    logic                     frame_start;

    modport master (
        output fb_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de, frame_start,
        input  fb_pxl
    );

    modport slave (
        input  fb_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de, frame_start,
        output fb_pxl
    );
endinterface

// File: rtl/vga_fb_reader.sv
// rtl/vga_fb_reader.sv - VGA timing + 2x2-upscaling frame-buffer scanner (optional FB_READER_BORDER_EN white edge)
module vga_fb_reader #(
    parameter int c_img_cols    = 320,
    parameter int c_img_rows    = 240,
    parameter int c_nb_img_pxls = 17,
    parameter int c_nb_buf      = 12,
    parameter int c_h_vis       = 640,
    parameter int c_h_fp        = 16,
    parameter int c_h_sync      = 96,
    parameter int c_h_bp        = 48,
    parameter int c_v_vis       = 480,
    parameter int c_v_fp        = 10,
    parameter int c_v_sync      = 2,
    parameter int c_v_bp        = 33
) (
    input  logic              clk,
    input  logic              rst,
    vga_fb_reader_if.master   bus
);
    localparam int c_h_tot = c_h_vis + c_h_fp + c_h_sync + c_h_bp;
    localparam int c_v_tot = c_v_vis + c_v_fp + c_v_sync + c_v_bp;
    localparam int c_nb_h  = $clog2(c_h_tot);
    localparam int c_nb_v  = $clog2(c_v_tot);

    localparam logic [c_nb_h-1:0] c_h_last     = c_nb_h'(c_h_tot - 1);
    localparam logic [c_nb_h-1:0] c_h_vis_l    = c_nb_h'(c_h_vis);
    localparam logic [c_nb_h-1:0] c_h_img      = c_nb_h'(2 * c_img_cols);
    localparam logic [c_nb_h-1:0] c_h_img_last = c_nb_h'(2 * c_img_cols - 1);
    localparam logic [c_nb_h-1:0] c_hs_beg     = c_nb_h'(c_h_vis + c_h_fp);
    localparam logic [c_nb_h-1:0] c_hs_end     = c_nb_h'(c_h_vis + c_h_fp + c_h_sync - 1);
    localparam logic [c_nb_v-1:0] c_v_last     = c_nb_v'(c_v_tot - 1);
    localparam logic [c_nb_v-1:0] c_v_vis_l    = c_nb_v'(c_v_vis);
    localparam logic [c_nb_v-1:0] c_v_img      = c_nb_v'(2 * c_img_rows);
    localparam logic [c_nb_v-1:0] c_v_img_last = c_nb_v'(2 * c_img_rows - 1);
    localparam logic [c_nb_v-1:0] c_vs_beg     = c_nb_v'(c_v_vis + c_v_fp);
    localparam logic [c_nb_v-1:0] c_vs_end     = c_nb_v'(c_v_vis + c_v_fp + c_v_sync - 1);
    localparam logic [c_nb_img_pxls-1:0] c_row_step = c_nb_img_pxls'(c_img_cols);

    logic [c_nb_h-1:0]        hc;
    logic [c_nb_v-1:0]        vc;
    logic [c_nb_img_pxls-1:0] line_base;
    logic [c_nb_img_pxls-1:0] fb_addr_q;
    logic h_wrap, v_wrap, de0, hs0, vs0, in_img0, fs0;
    logic de1, hs1, vs1, in_img1, fs1;
    logic [c_nb_buf-1:0] rgb_q;
    logic [c_nb_buf-1:0] pix;
    logic hs_q, vs_q, de_q, fs_q;

    assign h_wrap  = (hc == c_h_last);
    assign v_wrap  = (vc == c_v_last);
    assign de0     = (hc < c_h_vis_l) && (vc < c_v_vis_l);
    assign in_img0 = (hc < c_h_img) && (vc < c_v_img);
    assign hs0     = !((hc >= c_hs_beg) && (hc <= c_hs_end));
    assign vs0     = !((vc >= c_vs_beg) && (vc <= c_vs_end));
    assign fs0     = (hc == '0) && (vc == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hc <= '0;
            vc <= '0;
        end else if (h_wrap) begin
            hc <= '0;
            vc <= v_wrap ? '0 : vc + 1'b1;
        end else begin
            hc <= hc + 1'b1;
        end
    end

    // Each buffer row is scanned twice; line_base only advances after the odd display row,
    // and neither the last column nor the last row step past the final buffer address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_base <= '0;
            fb_addr_q <= '0;
        end else if (h_wrap) begin
            if (v_wrap) begin
                line_base <= '0;
                fb_addr_q <= '0;
            end else if (vc[0] && (vc < c_v_img_last)) begin
                line_base <= line_base + c_row_step;
                fb_addr_q <= line_base + c_row_step;
            end else begin
                fb_addr_q <= line_base;
            end
        end else if (in_img0 && hc[0] && (hc != c_h_img_last)) begin
            fb_addr_q <= fb_addr_q + 1'b1;
        end
    end

`ifdef FB_READER_BORDER_EN
    logic edge0, edge1;
    assign edge0 = in_img0 && ((hc == '0) || (hc == c_h_img_last) ||
                               (vc == '0) || (vc == c_v_img_last));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) edge1 <= 1'b0;
        else     edge1 <= edge0;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de1     <= 1'b0;
            hs1     <= 1'b1;
            vs1     <= 1'b1;
            in_img1 <= 1'b0;
            fs1     <= 1'b0;
        end else begin
            de1     <= de0;
            hs1     <= hs0;
            vs1     <= vs0;
            in_img1 <= in_img0;
            fs1     <= fs0;
        end
    end

    always_comb begin
        pix = '0;
        if (de1 && in_img1) pix = bus.fb_pxl;
`ifdef FB_READER_BORDER_EN
        if (de1 && in_img1 && edge1) pix = '1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            de_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            rgb_q <= pix;
            hs_q  <= hs1;
            vs_q  <= vs1;
            de_q  <= de1;
            fs_q  <= fs1;
        end
    end

    assign bus.fb_addr     = fb_addr_q;
    assign bus.vga_r       = rgb_q[11:8];
    assign bus.vga_g       = rgb_q[7:4];
    assign bus.vga_b       = rgb_q[3:0];
    assign bus.vga_hs      = hs_q;
    assign bus.vga_vs      = vs_q;
    assign bus.vga_de      = de_q;
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_vga_fb_reader.sv
// tb/tb_vga_fb_reader.sv - scaled-timing bench for vga_fb_reader with two image sizes
module tb_vga_fb_reader;
    localparam int HV = 20, HFP = 2, HS = 4, HBP = 3, HT = HV + HFP + HS + HBP;
    localparam int VV = 14, VFP = 2, VS = 2, VBP = 3, VT = VV + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int C0 = 8, R0 = 6, C1 = 4, R1 = 3;
    localparam int LOGN = 2 * FRAME;
    localparam int RH = 13, RV = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n;
    int   n_pass = 0, n_tot = 0;
    bit   chk_en = 1'b0, log_en = 1'b0;

    bit        hs_l[LOGN], vs_l[LOGN], de_l[LOGN], fs_l[LOGN], de1_l[LOGN];
    int        rgb_l[LOGN], rgb1_l[LOGN], addr_l[LOGN], addr1_l[LOGN];

    vga_fb_reader_if #(.c_nb_img_pxls(17), .c_nb_buf(12)) bus0 ();
    vga_fb_reader_if #(.c_nb_img_pxls(17), .c_nb_buf(12)) bus1 ();

    vga_fb_reader #(
        .c_img_cols(C0), .c_img_rows(R0), .c_nb_img_pxls(17), .c_nb_buf(12),
        .c_h_vis(HV), .c_h_fp(HFP), .c_h_sync(HS), .c_h_bp(HBP),
        .c_v_vis(VV), .c_v_fp(VFP), .c_v_sync(VS), .c_v_bp(VBP)
    ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    vga_fb_reader #(
        .c_img_cols(C1), .c_img_rows(R1), .c_nb_img_pxls(17), .c_nb_buf(12),
        .c_h_vis(HV), .c_h_fp(HFP), .c_h_sync(HS), .c_h_bp(HBP),
        .c_v_vis(VV), .c_v_fp(VFP), .c_v_sync(VS), .c_v_bp(VBP)
    ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    // Memory with one cycle of read latency whose content is its own address
    initial begin
        bus0.fb_pxl = '0;
        bus1.fb_pxl = '0;
    end
    always @(posedge clk) begin
        bus0.fb_pxl <= bus0.fb_addr[11:0];
        bus1.fb_pxl <= bus1.fb_addr[11:0];
    end

    // Cycles since reset release = index of the scan position the counters hold
    always @(posedge clk or posedge rst) begin
        if (rst) n <= 0;
        else     n <= n + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, exp);
    endtask

    function automatic int exp_rgb(input int k, input int cols, input int rows);
        int x = k % HT;
        int y = (k / HT) % VT;
        if (x >= HV || y >= VV) return 0;
        if (x >= 2 * cols || y >= 2 * rows) return 0;
`ifdef FB_READER_BORDER_EN
        if (x == 0 || y == 0 || x == 2 * cols - 1 || y == 2 * rows - 1) return 12'hFFF;
`endif
        return ((y / 2) * cols + x / 2) & 12'hFFF;
    endfunction

    function automatic int exp_de(input int k);
        return ((k % HT) < HV && ((k / HT) % VT) < VV) ? 1 : 0;
    endfunction

    function automatic int exp_hs(input int k);
        int x = k % HT;
        return (x >= HV + HFP && x < HV + HFP + HS) ? 0 : 1;
    endfunction

    function automatic int exp_vs(input int k);
        int y = (k / HT) % VT;
        return (y >= VV + VFP && y < VV + VFP + VS) ? 0 : 1;
    endfunction

    function automatic bit in_img(input int k, input int cols, input int rows);
        return ((k % HT) < 2 * cols) && (((k / HT) % VT) < 2 * rows);
    endfunction

    function automatic int exp_addr(input int k, input int cols);
        return (((k / HT) % VT) / 2) * cols + (k % HT) / 2;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            int k;
            if (n < 2) begin
                chk("rst_hs", bus0.vga_hs, 1);
                chk("rst_vs", bus0.vga_vs, 1);
                chk("rst_de", bus0.vga_de, 0);
                chk("rst_rgb", {bus0.vga_r, bus0.vga_g, bus0.vga_b}, 0);
                chk("rst_fs", bus0.frame_start, 0);
            end else begin
                k = n - 2;
                chk("hs", bus0.vga_hs, exp_hs(k));
                chk("vs", bus0.vga_vs, exp_vs(k));
                chk("de", bus0.vga_de, exp_de(k));
                chk("fs", bus0.frame_start, (k % FRAME == 0) ? 1 : 0);
                chk("rgb0", {bus0.vga_r, bus0.vga_g, bus0.vga_b}, exp_rgb(k, C0, R0));
                chk("rgb1", {bus1.vga_r, bus1.vga_g, bus1.vga_b}, exp_rgb(k, C1, R1));
                chk("de1", bus1.vga_de, exp_de(k));
                if (log_en && k < LOGN) begin
                    hs_l[k]   = bus0.vga_hs;
                    vs_l[k]   = bus0.vga_vs;
                    de_l[k]   = bus0.vga_de;
                    fs_l[k]   = bus0.frame_start;
                    rgb_l[k]  = {bus0.vga_r, bus0.vga_g, bus0.vga_b};
                    rgb1_l[k] = {bus1.vga_r, bus1.vga_g, bus1.vga_b};
                    de1_l[k]  = bus1.vga_de;
                end
            end
            if (in_img(n, C0, R0)) chk("addr0", bus0.fb_addr, exp_addr(n, C0));
            if (in_img(n, C1, R1)) chk("addr1", bus1.fb_addr, exp_addr(n, C1));
            chk("addr0_range", (bus0.fb_addr < C0 * R0) ? 1 : 0, 1);
            chk("addr1_range", (bus1.fb_addr < C1 * R1) ? 1 : 0, 1);
            if (log_en && n < LOGN) begin
                addr_l[n]  = bus0.fb_addr;
                addr1_l[n] = bus1.fb_addr;
            end
        end
    end

    initial begin
        int f1, f2, lw, cnt, lines, mx, mx1;
        bit found;
        chk_en = 1'b1;
        log_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) #1 rst = 1'b0;
        repeat (LOGN + 4) @(posedge clk);
        @(negedge clk) log_en = 1'b0;

        f1 = -1; f2 = -1;
        for (int k = 1; k < LOGN; k++)
            if (hs_l[k-1] && !hs_l[k]) begin
                if (f1 < 0) f1 = k; else if (f2 < 0) f2 = k;
            end
        chk("hs_first_fall", f1, HV + HFP);
        chk("hs_period", f2 - f1, HT);
        lw = 0;
        if (f1 >= 0 && f2 > f1) for (int k = f1; k < f2; k++) if (!hs_l[k]) lw++;
        chk("hs_low", lw, HS);

        f1 = -1; f2 = -1;
        for (int k = 1; k < LOGN; k++)
            if (vs_l[k-1] && !vs_l[k]) begin
                if (f1 < 0) f1 = k; else if (f2 < 0) f2 = k;
            end
        chk("vs_period", f2 - f1, 609);
        lw = 0;
        if (f1 >= 0 && f2 > f1) for (int k = f1; k < f2; k++) if (!vs_l[k]) lw++;
        chk("vs_low", lw, 58);

        cnt = 0; lines = 0;
        for (int y = 0; y < VT; y++) begin
            found = 1'b0;
            for (int x = 0; x < HT; x++) if (de_l[y*HT+x]) begin cnt++; found = 1'b1; end
            if (found) lines++;
        end
        chk("de_count", cnt, 280);
        chk("de_lines", lines, 14);
        cnt = 0;
        for (int k = 0; k < LOGN; k++) if (fs_l[k]) cnt++;
        chk("fs_count", cnt, 2);
        chk("fs_second", fs_l[609], 1);

`ifdef FB_READER_BORDER_EN
        chk("px_0_0", rgb_l[0], 12'hFFF);
        chk("px_1_1", rgb_l[HT + 1], 0);
`else
        chk("px_0_0", rgb_l[0], 0);
        chk("px_1_0", rgb_l[1], 0);
        chk("px_0_1", rgb_l[HT], 0);
        chk("px_1_1", rgb_l[HT + 1], 0);
        chk("px_2_0", rgb_l[2], 1);
        chk("px_0_2", rgb_l[2*HT], 8);
        chk("px_15_11", rgb_l[11*HT + 15], 47);
        chk("d1_px_7_5", rgb1_l[5*HT + 7], 11);
`endif
        chk("px_16_0_black", rgb_l[16], 0);
        chk("px_16_0_de", de_l[16], 1);
        chk("d1_px_8_0_black", rgb1_l[8], 0);
        chk("d1_px_8_0_de", de1_l[8], 1);
        chk("d1_px_0_6_black", rgb1_l[6*HT], 0);

        chk("addr_row1", addr_l[HT], 0);
        chk("addr_row2", addr_l[2*HT], 8);
        chk("addr_row11", addr_l[11*HT], 40);
        chk("addr_last", addr_l[11*HT + 15], 47);
        mx = 0; mx1 = 0;
        for (int k = 0; k < FRAME; k++) begin
            if (addr_l[k] > mx) mx = addr_l[k];
            if (addr1_l[k] > mx1) mx1 = addr1_l[k];
        end
        chk("addr0_max", mx, 47);
        chk("addr1_max", mx1, 11);

        cnt = 0;
        do begin @(negedge clk); cnt++; end
        while ((n % FRAME) != RV * HT + RH && cnt < FRAME + 10);
        chk("reach_mid_frame", n % FRAME, RV * HT + RH);
        #1 rst = 1'b1;
        #1;
        chk("async_hs", bus0.vga_hs, 1);
        chk("async_vs", bus0.vga_vs, 1);
        chk("async_de", bus0.vga_de, 0);
        chk("async_rgb", {bus0.vga_r, bus0.vga_g, bus0.vga_b}, 0);
        chk("async_fs", bus0.frame_start, 0);
        chk("async_addr", bus0.fb_addr, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) #1 rst = 1'b0;
        cnt = 0;
        do begin @(negedge clk); cnt++; end
        while (!bus0.frame_start && cnt < 10);
        chk("fs_after_rst", cnt, 2);
        cnt = 0;
        do begin @(negedge clk); cnt++; end
        while (bus0.vga_vs && cnt < 2000);
        chk("vs_after_rst", cnt, (VV + VFP) * HT);
        repeat (50) @(negedge clk);
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
